rob_mc: RTL and testbench
=========================

Name: rob_mc

Overview:
- Parametrised reorder buffer; successor to the single-commit 32-entry ROB.
- Sits between dispatch, CDB, store buffer, FRL/CFC and retirement RAT.
- Depth and field widths are parameters; retires up to COMMIT_W in-order instructions per cycle.
- Supports tag-based flush rollback and exposes an occupancy count.

Parameters:
- DEPTH, 32, entry count; power of 2, >=4.
- COMMIT_W, 2, max retirements per cycle (1..4).
- ARCH_W, 5, architectural register number width.
- PHY_W, 6, physical register number width.
- ADDR_W, 32, store word address width.
- TAG_W, $clog2(DEPTH), derived (localparam); ROB tag width.

Ports:
- clk in 1: clock.
- rst_b in 1: asynchronous active-low reset.
- cdb_val in 1: CDB broadcast valid.
- cdb_robtag in TAG_W: tag of the completing instruction.
- cdb_swaddr in ADDR_W: store address accompanying completion.
- cdb_flush in 1: misprediction flush.
- cfc_robtag in TAG_W: tag of the branch that holds the checkpoint.
- dis_inst_valid in 1: dispatch request.
- dis_inst_sw in 1: instruction is a store.
- dis_reg_write in 1: instruction writes a register.
- dis_rob_rdaddr in ARCH_W: architectural destination.
- dis_new_rd_phy_addr in PHY_W: newly allocated physical register.
- dis_prev_phy_addr in PHY_W: previous mapping of the destination.
- dis_sw_rt_phy_addr in PHY_W: store data source; forwarded to the store buffer.
- sb_full in 1: store buffer cannot accept.
- rob_full out 1: ROB full.
- rob_two_or_more_vacant out 1: at least 2 entries free.
- rob_count out TAG_W+1: occupied entries.
- rob_wrptr out TAG_W: tag assigned to the next dispatch.
- rob_rdptr out TAG_W: head tag.
- rob_commit out COMMIT_W: per-slot commit strobe.
- rob_commitregwrite out COMMIT_W: per-slot register write.
- rob_commitrdaddr out COMMIT_W*ARCH_W: per-slot architectural destination.
- rob_commitprephyaddr out COMMIT_W*PHY_W: per-slot previous physical register (to FRL).
- rob_commitcurrphyaddr out COMMIT_W*PHY_W: per-slot current physical register (to RRAT).
- rob_commitmemwrite out 1: store retiring in slot 0.
- rob_swaddr out ADDR_W: address of the retiring store.
- rob_sw_rt_phy_addr out PHY_W: data register of the retiring store.

Behaviour:
- Entry fields: valid, done, regwrite, is_sw, rd, cur_phy, prev_phy, sw_rt_phy, swaddr.
- Read and write pointers are TAG_W+1 bits, with the MSB as the wrap bit.
- rob_count is wrptr minus rdptr.
- rob_full is count==DEPTH.
- rob_two_or_more_vacant is count<=DEPTH-2.

Reset:
- Pointers, count and all valid/done bits are 0; every commit output is 0.
- rob_full=0, rob_two_or_more_vacant=1.
- Reset takes effect immediately, including mid-flush or mid-commit.

Dispatch:
- dis_inst_valid && !rob_full writes the entry at wrptr, with done=0 (done=1 if dis_inst_sw=0 && dis_reg_write=0, i.e. a nop).
- wrptr increments at the next edge.
- Dispatch while full is dropped and wrptr is held; the bench asserts this never happens.

Completion:
- cdb_val sets done, and swaddr if is_sw, on entry cdb_robtag when that entry is valid.
- A completion on an invalid entry is ignored.
- done is registered, so an entry cannot retire in the same cycle it completes.

Commit (combinational from registered state):
- Slot k retires entry rdptr+k iff slot k-1 retires (slot 0 has no such condition), the entry is valid && done, and k<count.
- A store may retire only in slot 0, and only if !sb_full; a store at slot k>0 stops retirement at that slot.
- rob_commitmemwrite = rob_commit[0] && is_sw.
- rdptr advances by the number of retiring slots at the next edge, and those entries are cleared.

Flush:
- cdb_flush squashes every entry younger than cfc_robtag; the entry at cfc_robtag itself stays.
- Next wrptr = cfc_robtag+1, with the wrap bit chosen so that the new count equals (cfc_robtag-rdptr mod DEPTH)+1.
- Squashed entries have valid cleared.
- Flush overrides a same-cycle dispatch (dispatch dropped) and a same-cycle completion to a squashed tag.
- Same-cycle commits still occur.
- cfc_robtag must be valid; a flush to an invalid tag is ignored and flagged by an assertion.

Simultaneous events:
- Dispatch, completion and commit all in one cycle are legal.
- Count is updated by +dispatch minus retired.
- Wrap-around is modulo DEPTH on the index; the wrap bit toggles.

Decomposition:
- Package rob_pkg: rob_entry_t struct, parameterised by widths through localparams.
- Package rob_pkg: function retire_count().
- Sub-module rob_commit_sel: combinational retire-slot selection (inputs: head entries, count, sb_full; outputs: commit vector).

Test Plan:
1. DEPTH=8: reset, then dispatch 8 regwrite instructions -> rob_full=1 at count 8; rob_two_or_more_vacant=0 from count 7; a 9th dispatch is dropped and wrptr stays 0.
2. Complete tags 0 and 1 on the CDB in one cycle each -> two cycles later rob_commit=2'b11 in one cycle, rdptr 0->2, FRL receives both prev_phy values.
3. Store at tag 0 done, sb_full=1 -> no commit. Drop sb_full -> rob_commitmemwrite=1 and rob_swaddr matches the CDB value (e.g. 0x0000_1040).
4. Tags 0..5 valid, flush with cfc_robtag=2 -> next cycle wrptr=3, count=3, and a CDB completion on tag 4 is ignored.
5. Wrap: commit and dispatch continuously for 20 cycles -> tags wrap 7->0, count stays consistent, no lost or duplicated retirement (scoreboard).
6. Assert rst_b mid-flush while full -> all outputs return to reset values asynchronously, with no commit strobe.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types and helpers for the multi-commit reorder buffer.
// Entry widths here set the storage layout used by rob_mc.
package rob_pkg;

   localparam int RB_ARCH_W = 5;
   localparam int RB_PHY_W  = 6;
   localparam int RB_ADDR_W = 32;
   localparam int RB_CW_MAX = 4;

   typedef struct packed {
      logic                 valid;
      logic                 done;
      logic                 regwrite;
      logic                 is_sw;
      logic [RB_ARCH_W-1:0] rd;
      logic [RB_PHY_W-1:0]  cur_phy;
      logic [RB_PHY_W-1:0]  prev_phy;
      logic [RB_PHY_W-1:0]  sw_rt_phy;
      logic [RB_ADDR_W-1:0] swaddr;
   } rob_entry_t;

   // Retire vector is a contiguous run from slot 0, so popcount == depth.
   function automatic logic [2:0] retire_count(
      input logic [RB_CW_MAX-1:0] v
   );
      logic [2:0] n;
      n = '0;
      for (int k = 0; k < RB_CW_MAX; k++) begin
         if (v[k]) n = n + 3'd1;
      end
      return n;
   endfunction

endpackage

// File: rtl/rob_commit_sel.sv
// Picks which head slots retire this cycle; stores only in slot 0,
// and any blocked slot stops every younger slot behind it.
module rob_commit_sel
   import rob_pkg::*;
#(
   parameter int COMMIT_W = 2,
   parameter int CNT_W    = 6
) (
   input  logic [COMMIT_W-1:0] i_valid,
   input  logic [COMMIT_W-1:0] i_done,
   input  logic [COMMIT_W-1:0] i_is_sw,
   input  logic [CNT_W-1:0]    i_count,
   input  logic                i_sb_full,
   output logic [COMMIT_W-1:0] o_commit
);

   always_comb begin
      logic w_go;
      w_go     = 1'b1;
      o_commit = '0;
      for (int k = 0; k < COMMIT_W; k++) begin
         w_go = w_go && i_valid[k] && i_done[k]
              && (CNT_W'(k) < i_count)
              && (!i_is_sw[k] || (k == 0 && !i_sb_full));
         o_commit[k] = w_go;
      end
   end

endmodule

// File: rtl/rob_mc.sv
// Reorder buffer retiring up to COMMIT_W instructions per cycle,
// with tag-based flush rollback and an occupancy count.
module rob_mc
   import rob_pkg::*;
#(
   parameter int DEPTH    = 32,
   parameter int COMMIT_W = 2,
   parameter int ARCH_W   = RB_ARCH_W,
   parameter int PHY_W    = RB_PHY_W,
   parameter int ADDR_W   = RB_ADDR_W,
   localparam int TAG_W   = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst_b,
   input  logic                     cdb_val,
   input  logic [TAG_W-1:0]         cdb_robtag,
   input  logic [ADDR_W-1:0]        cdb_swaddr,
   input  logic                     cdb_flush,
   input  logic [TAG_W-1:0]         cfc_robtag,
   input  logic                     dis_inst_valid,
   input  logic                     dis_inst_sw,
   input  logic                     dis_reg_write,
   input  logic [ARCH_W-1:0]        dis_rob_rdaddr,
   input  logic [PHY_W-1:0]         dis_new_rd_phy_addr,
   input  logic [PHY_W-1:0]         dis_prev_phy_addr,
   input  logic [PHY_W-1:0]         dis_sw_rt_phy_addr,
   input  logic                     sb_full,
   output logic                     rob_full,
   output logic                     rob_two_or_more_vacant,
   output logic [TAG_W:0]           rob_count,
   output logic [TAG_W-1:0]         rob_wrptr,
   output logic [TAG_W-1:0]         rob_rdptr,
   output logic [COMMIT_W-1:0]      rob_commit,
   output logic [COMMIT_W-1:0]      rob_commitregwrite,
   output logic [COMMIT_W*ARCH_W-1:0] rob_commitrdaddr,
   output logic [COMMIT_W*PHY_W-1:0]  rob_commitprephyaddr,
   output logic [COMMIT_W*PHY_W-1:0]  rob_commitcurrphyaddr,
   output logic                     rob_commitmemwrite,
   output logic [ADDR_W-1:0]        rob_swaddr,
   output logic [PHY_W-1:0]         rob_sw_rt_phy_addr
);

   localparam int PW = TAG_W + 1;

   rob_entry_t r_rob [DEPTH];
   rob_entry_t w_nxt [DEPTH];

   logic [PW-1:0]       r_wr, r_rd, w_cnt, w_flush_cnt;
   logic [TAG_W-1:0]    w_rd_idx, w_wr_idx, w_cfc_off;
   logic [TAG_W-1:0]    w_hidx [COMMIT_W];
   logic [COMMIT_W-1:0] w_hv, w_hd, w_hs, w_commit;
   logic [2:0]          w_nret;
   logic                w_flush, w_dis, w_cmp;

   assign w_rd_idx  = r_rd[TAG_W-1:0];
   assign w_wr_idx  = r_wr[TAG_W-1:0];
   assign w_cnt     = r_wr - r_rd;
   assign rob_count = w_cnt;
   assign rob_wrptr = w_wr_idx;
   assign rob_rdptr = w_rd_idx;
   assign rob_full  = (w_cnt == PW'(DEPTH));
   assign rob_two_or_more_vacant = (w_cnt <= PW'(DEPTH - 2));

   assign w_flush = cdb_flush && r_rob[cfc_robtag].valid;
   assign w_dis   = dis_inst_valid && !rob_full && !w_flush;
   assign w_cmp   = cdb_val && r_rob[cdb_robtag].valid;

   // Survivors are head..cfc inclusive; this also fixes the wrap bit.
   assign w_cfc_off   = cfc_robtag - w_rd_idx;
   assign w_flush_cnt = PW'(w_cfc_off) + PW'(1);

   always_comb begin
      for (int k = 0; k < COMMIT_W; k++) begin
         w_hidx[k] = w_rd_idx + TAG_W'(k);
         w_hv[k]   = r_rob[w_hidx[k]].valid;
         w_hd[k]   = r_rob[w_hidx[k]].done;
         w_hs[k]   = r_rob[w_hidx[k]].is_sw;
      end
   end

   rob_commit_sel #(
      .COMMIT_W (COMMIT_W),
      .CNT_W    (PW)
   ) u_sel (
      .i_valid   (w_hv),
      .i_done    (w_hd),
      .i_is_sw   (w_hs),
      .i_count   (w_cnt),
      .i_sb_full (sb_full),
      .o_commit  (w_commit)
   );

   assign w_nret = retire_count(RB_CW_MAX'(w_commit));

   always_comb begin
      logic [TAG_W-1:0] w_off;
      w_off = '0;
      w_nxt = r_rob;
      if (w_cmp) begin
         w_nxt[cdb_robtag].done = 1'b1;
         if (r_rob[cdb_robtag].is_sw)
            w_nxt[cdb_robtag].swaddr = RB_ADDR_W'(cdb_swaddr);
      end
      for (int k = 0; k < COMMIT_W; k++) begin
         if (w_commit[k]) begin
            w_nxt[w_hidx[k]].valid = 1'b0;
            w_nxt[w_hidx[k]].done  = 1'b0;
         end
      end
      if (w_dis) begin
         w_nxt[w_wr_idx].valid     = 1'b1;
         w_nxt[w_wr_idx].done      = !dis_inst_sw && !dis_reg_write;
         w_nxt[w_wr_idx].regwrite  = dis_reg_write;
         w_nxt[w_wr_idx].is_sw     = dis_inst_sw;
         w_nxt[w_wr_idx].rd        = RB_ARCH_W'(dis_rob_rdaddr);
         w_nxt[w_wr_idx].cur_phy   = RB_PHY_W'(dis_new_rd_phy_addr);
         w_nxt[w_wr_idx].prev_phy  = RB_PHY_W'(dis_prev_phy_addr);
         w_nxt[w_wr_idx].sw_rt_phy = RB_PHY_W'(dis_sw_rt_phy_addr);
         w_nxt[w_wr_idx].swaddr    = '0;
      end
      if (w_flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            w_off = TAG_W'(i) - w_rd_idx;
            if (w_off > w_cfc_off) begin
               w_nxt[i].valid = 1'b0;
               w_nxt[i].done  = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_wr <= '0;
         r_rd <= '0;
         for (int i = 0; i < DEPTH; i++) r_rob[i] <= '0;
      end else begin
         r_rob <= w_nxt;
         r_rd  <= r_rd + PW'(w_nret);
         if (w_flush)    r_wr <= r_rd + w_flush_cnt;
         else if (w_dis) r_wr <= r_wr + PW'(1);
      end
   end

   assign rob_commit = w_commit;

   always_comb begin
      rob_commitregwrite    = '0;
      rob_commitrdaddr      = '0;
      rob_commitprephyaddr  = '0;
      rob_commitcurrphyaddr = '0;
      for (int k = 0; k < COMMIT_W; k++) begin
         if (w_commit[k]) begin
            rob_commitregwrite[k] = r_rob[w_hidx[k]].regwrite;
            rob_commitrdaddr[k*ARCH_W +: ARCH_W] =
               r_rob[w_hidx[k]].rd[ARCH_W-1:0];
            rob_commitprephyaddr[k*PHY_W +: PHY_W] =
               r_rob[w_hidx[k]].prev_phy[PHY_W-1:0];
            rob_commitcurrphyaddr[k*PHY_W +: PHY_W] =
               r_rob[w_hidx[k]].cur_phy[PHY_W-1:0];
         end
      end
   end

   assign rob_commitmemwrite = w_commit[0] && w_hs[0];
   assign rob_swaddr = rob_commitmemwrite ?
      r_rob[w_rd_idx].swaddr[ADDR_W-1:0] : '0;
   assign rob_sw_rt_phy_addr = rob_commitmemwrite ?
      r_rob[w_rd_idx].sw_rt_phy[PHY_W-1:0] : '0;

   a_flush_tag : assert property (
      @(posedge clk) disable iff (!rst_b)
      cdb_flush |-> r_rob[cfc_robtag].valid
   );

endmodule

// File: tb/tb_rob_mc.sv
// Scoreboard bench for rob_mc at DEPTH=8, COMMIT_W=2.
module tb_rob_mc;

   logic        clk, rst_b;
   logic        cdb_val, cdb_flush, dis_inst_valid, dis_inst_sw;
   logic        dis_reg_write, sb_full;
   logic [2:0]  cdb_robtag, cfc_robtag;
   logic [31:0] cdb_swaddr;
   logic [4:0]  dis_rob_rdaddr;
   logic [5:0]  dis_new_rd_phy_addr, dis_prev_phy_addr;
   logic [5:0]  dis_sw_rt_phy_addr;
   logic        rob_full, rob_two_or_more_vacant, rob_commitmemwrite;
   logic [3:0]  rob_count;
   logic [2:0]  rob_wrptr, rob_rdptr;
   logic [1:0]  rob_commit, rob_commitregwrite;
   logic [9:0]  rob_commitrdaddr;
   logic [11:0] rob_commitprephyaddr, rob_commitcurrphyaddr;
   logic [31:0] rob_swaddr;
   logic [5:0]  rob_sw_rt_phy_addr;

   rob_mc #(.DEPTH(8), .COMMIT_W(2)) dut (
      .clk(clk), .rst_b(rst_b),
      .cdb_val(cdb_val), .cdb_robtag(cdb_robtag),
      .cdb_swaddr(cdb_swaddr), .cdb_flush(cdb_flush),
      .cfc_robtag(cfc_robtag),
      .dis_inst_valid(dis_inst_valid), .dis_inst_sw(dis_inst_sw),
      .dis_reg_write(dis_reg_write), .dis_rob_rdaddr(dis_rob_rdaddr),
      .dis_new_rd_phy_addr(dis_new_rd_phy_addr),
      .dis_prev_phy_addr(dis_prev_phy_addr),
      .dis_sw_rt_phy_addr(dis_sw_rt_phy_addr),
      .sb_full(sb_full),
      .rob_full(rob_full),
      .rob_two_or_more_vacant(rob_two_or_more_vacant),
      .rob_count(rob_count), .rob_wrptr(rob_wrptr),
      .rob_rdptr(rob_rdptr), .rob_commit(rob_commit),
      .rob_commitregwrite(rob_commitregwrite),
      .rob_commitrdaddr(rob_commitrdaddr),
      .rob_commitprephyaddr(rob_commitprephyaddr),
      .rob_commitcurrphyaddr(rob_commitcurrphyaddr),
      .rob_commitmemwrite(rob_commitmemwrite),
      .rob_swaddr(rob_swaddr),
      .rob_sw_rt_phy_addr(rob_sw_rt_phy_addr)
   );

   typedef struct {
      int          tag;
      bit          sw;
      bit          rw;
      logic [4:0]  rd;
      logic [5:0]  np;
      logic [5:0]  pp;
      logic [5:0]  sr;
      logic [31:0] addr;
   } exp_t;

   exp_t q[$];
   exp_t m_e;
   int   n_chk, n_fail, m_wr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      dis_inst_valid = 1'b0;
      cdb_val        = 1'b0;
      cdb_flush      = 1'b0;
   endtask

   task automatic set_dis(input bit sw, input bit rw, input int rd,
                          input int np, input int pp, input int sr);
      exp_t e;
      dis_inst_valid      = 1'b1;
      dis_inst_sw         = sw;
      dis_reg_write       = rw;
      dis_rob_rdaddr      = 5'(rd);
      dis_new_rd_phy_addr = 6'(np);
      dis_prev_phy_addr   = 6'(pp);
      dis_sw_rt_phy_addr  = 6'(sr);
      if (q.size() < 8) begin
         e.tag = m_wr; e.sw = sw; e.rw = rw;
         e.rd = 5'(rd); e.np = 6'(np); e.pp = 6'(pp);
         e.sr = 6'(sr); e.addr = '0;
         q.push_back(e);
         m_wr = (m_wr + 1) % 8;
      end
   endtask

   task automatic set_cmp(input int t, input logic [31:0] a);
      cdb_val    = 1'b1;
      cdb_robtag = 3'(t);
      cdb_swaddr = a;
      foreach (q[i]) if (q[i].tag == t && q[i].sw) q[i].addr = a;
   endtask

   task automatic set_flush(input int t);
      cdb_flush  = 1'b1;
      cfc_robtag = 3'(t);
      while (q.size() > 0 && q[$].tag != t) void'(q.pop_back());
      m_wr = (t + 1) % 8;
   endtask

   task automatic do_reset();
      rst_b = 1'b0;
      q.delete();
      m_wr = 0;
      clr();
      sb_full = 1'b0;
      tick();
      rst_b = 1'b1;
   endtask

   // Retirement monitor: every strobed slot must match the oldest entry.
   always @(negedge clk) begin
      if (rst_b) begin
         for (int k = 0; k < 2; k++) begin
            if (rob_commit[k]) begin
               if (q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL spurious_commit slot=%0d", k);
               end else begin
                  m_e = q.pop_front();
                  chk($sformatf("retire_s%0d_t%0d", k, m_e.tag),
                      {rob_commitregwrite[k], rob_commitrdaddr[k*5 +: 5],
                       rob_commitprephyaddr[k*6 +: 6],
                       rob_commitcurrphyaddr[k*6 +: 6]},
                      {m_e.rw, m_e.rd, m_e.pp, m_e.np});
                  if (k == 0) begin
                     chk("memwrite", rob_commitmemwrite, m_e.sw);
                     if (m_e.sw)
                        chk("store_data",
                            {rob_swaddr, rob_sw_rt_phy_addr},
                            {m_e.addr, m_e.sr});
                  end
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int pt;
      n_chk = 0; n_fail = 0; m_wr = 0;
      rst_b = 1'b0; sb_full = 1'b0;
      clr();
      cdb_robtag = '0; cfc_robtag = '0; cdb_swaddr = '0;
      dis_inst_sw = 1'b0; dis_reg_write = 1'b0; dis_rob_rdaddr = '0;
      dis_new_rd_phy_addr = '0; dis_prev_phy_addr = '0;
      dis_sw_rt_phy_addr = '0;
      #1;
      chk("rst_count", rob_count, 0);
      chk("rst_full", rob_full, 0);
      chk("rst_vac", rob_two_or_more_vacant, 1);
      chk("rst_commit", rob_commit, 0);
      tick();
      rst_b = 1'b1;

      // fill to full, then one dropped dispatch
      for (int i = 0; i < 8; i++) begin
         set_dis(0, 1, i + 1, 8 + i, 32 + i, 0);
         tick(); clr();
         chk($sformatf("t1_count%0d", i), rob_count, i + 1);
         chk($sformatf("t1_full%0d", i), rob_full, i == 7);
         chk($sformatf("t1_vac%0d", i), rob_two_or_more_vacant, i < 6);
      end
      set_dis(0, 1, 30, 30, 30, 0);
      tick(); clr();
      chk("t1_wrptr_hold", rob_wrptr, 0);
      chk("t1_count_hold", rob_count, 8);

      // dual retirement
      set_cmp(1, 0); tick(); clr();
      chk("t2_no_commit", rob_commit, 2'b00);
      set_cmp(0, 0); tick(); clr();
      chk("t2_commit", rob_commit, 2'b11);
      chk("t2_regwrite", rob_commitregwrite, 2'b11);
      chk("t2_prephy", rob_commitprephyaddr, 12'h860);
      tick();
      chk("t2_rdptr", rob_rdptr, 2);
      chk("t2_count", rob_count, 6);

      // stores and sb_full backpressure
      do_reset();
      set_dis(1, 0, 0, 0, 0, 33); tick(); clr();
      set_dis(1, 0, 0, 0, 0, 34); tick(); clr();
      sb_full = 1'b1;
      set_cmp(0, 32'h0000_1040); tick(); clr();
      set_cmp(1, 32'h0000_2080); tick(); clr();
      chk("t3_blocked", rob_commit, 2'b00);
      chk("t3_count", rob_count, 2);
      sb_full = 1'b0;
      #1;
      chk("t3_commit0", rob_commit, 2'b01);
      chk("t3_memwr", rob_commitmemwrite, 1);
      chk("t3_swaddr", rob_swaddr, 32'h0000_1040);
      chk("t3_swrt", rob_sw_rt_phy_addr, 33);
      tick();
      chk("t3_commit1", rob_commit, 2'b01);
      chk("t3_swaddr1", rob_swaddr, 32'h0000_2080);
      tick();
      chk("t3_empty", rob_count, 0);

      // flush rollback
      do_reset();
      for (int i = 0; i < 6; i++) begin
         set_dis(0, 1, 10 + i, 20 + i, 40 + i, 0);
         tick(); clr();
      end
      set_cmp(4, 0);
      set_flush(2);
      dis_inst_valid = 1'b1;
      tick(); clr();
      chk("t4_wrptr", rob_wrptr, 3);
      chk("t4_count", rob_count, 3);
      set_cmp(4, 0); tick(); clr();
      chk("t4_cmp_ignored", rob_count, 3);
      set_dis(0, 1, 20, 30, 50, 0); tick(); clr();
      set_dis(0, 1, 21, 31, 51, 0); tick(); clr();
      for (int t = 0; t < 4; t++) begin
         set_cmp(t, 0); tick(); clr();
      end
      tick(); tick(); tick();
      chk("t4_count_left", rob_count, 1);
      chk("t4_rdptr", rob_rdptr, 4);
      set_cmp(4, 0); tick(); clr();
      tick(); tick();
      chk("t4_drain", rob_count, 0);
      chk("t4_wrptr2", rob_wrptr, 5);

      // continuous dispatch/commit across the wrap
      pt = -1;
      for (int c = 0; c < 20; c++) begin
         int t;
         t = m_wr;
         set_dis(0, (c % 3) != 2, c % 32, c, c + 20, 0);
         if (pt >= 0) set_cmp(pt, 0);
         pt = t;
         tick(); clr();
         chk($sformatf("t5_count%0d", c), rob_count, q.size());
      end
      set_cmp(pt, 0); tick(); clr();
      tick(); tick(); tick();
      chk("t5_drain", rob_count, 0);
      chk("t5_sb_empty", q.size(), 0);
      chk("t5_wrptr", rob_wrptr, 1);

      // async reset during a flush while full
      for (int i = 0; i < 8; i++) begin
         set_dis(0, 1, i + 2, i + 3, i + 4, 0);
         tick(); clr();
      end
      chk("t6_full", rob_full, 1);
      set_cmp(2, 0); tick(); clr();
      set_cmp(1, 0); tick(); clr();
      chk("t6_pending", rob_commit, 2'b11);
      set_flush(4);
      #2;
      rst_b = 1'b0;
      q.delete();
      m_wr = 0;
      #1;
      chk("t6_count", rob_count, 0);
      chk("t6_full0", rob_full, 0);
      chk("t6_vac", rob_two_or_more_vacant, 1);
      chk("t6_commit", rob_commit, 0);
      chk("t6_memwr", rob_commitmemwrite, 0);
      chk("t6_prephy", rob_commitprephyaddr, 0);
      chk("t6_ptrs", {rob_wrptr, rob_rdptr}, 0);
      clr();
      tick();
      rst_b = 1'b1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
